control_sequencer: RTL and testbench

//  Microprogram sequencer for the multicycle MIPS datapath; consumer of the instruction encoder's State_Sel dispatch.

---
 rtl/control_sequencer_pkg.sv | 25 ++
 rtl/control_sequencer_next_state_mux.sv | 66 ++++++
 rtl/control_sequencer.sv | 98 +++++++++
 tb/tb_control_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared microstore definitions: next-mode encodings, default state numbers
// and the decode flags passed from the next-state mux to the registers.
package control_sequencer_pkg;

    localparam logic [2:0] NM_ENCODE = 3'd0;
    localparam logic [2:0] NM_INCR   = 3'd1;
    localparam logic [2:0] NM_JUMP   = 3'd2;
    localparam logic [2:0] NM_WAIT   = 3'd3;
    localparam logic [2:0] NM_COND   = 3'd4;
    localparam logic [2:0] NM_CALL   = 3'd5;
    localparam logic [2:0] NM_RET    = 3'd6;
    localparam logic [2:0] NM_FETCH  = 3'd7;

    localparam int DEF_FETCH_STATE = 1;
    localparam int DEF_ERR_STATE   = 127;

    typedef struct packed {
        logic illegal;
        logic hold;
        logic timeout;
        logic push;
        logic pop;
    } ns_flags_t;

endpackage

// File: rtl/control_sequencer_next_state_mux.sv
// Combinational 8-way next-state select; also reports which side
// effects (count, hold, timeout, call push, return pop) the mode implies.
module next_state_mux
    import control_sequencer_pkg::*;
#(
    parameter int STATE_W     = 7,
    parameter int FETCH_STATE = DEF_FETCH_STATE,
    parameter int ERR_STATE   = DEF_ERR_STATE
) (
    input  logic [STATE_W-1:0] state_i,
    input  logic [2:0]         mode_i,
    input  logic [STATE_W-1:0] sel_i,
    input  logic [STATE_W-1:0] cr_addr_i,
    input  logic               cond_i,
    input  logic               inv_i,
    input  logic               moc_i,
    input  logic               wait_done_i,
    input  logic               ret_valid_i,
    input  logic [STATE_W-1:0] ret_addr_i,
    output logic [STATE_W-1:0] next_o,
    output ns_flags_t          flags_o
);

    logic [STATE_W-1:0] inc;
    assign inc = state_i + STATE_W'(1);

    always_comb begin
        next_o  = inc;
        flags_o = '0;
        unique case (mode_i)
            NM_ENCODE: begin
                next_o          = sel_i;
                flags_o.illegal = (sel_i == STATE_W'(FETCH_STATE));
            end
            NM_INCR:  next_o = inc;
            NM_JUMP:  next_o = cr_addr_i;
            NM_WAIT: begin
                // MOC arriving on the timeout cycle still advances normally
                if (moc_i) begin
                    next_o = inc;
                end else if (wait_done_i) begin
                    next_o          = STATE_W'(ERR_STATE);
                    flags_o.timeout = 1'b1;
                end else begin
                    next_o       = state_i;
                    flags_o.hold = 1'b1;
                end
            end
            NM_COND:  next_o = (cond_i ^ inv_i) ? cr_addr_i : inc;
            NM_CALL: begin
                next_o       = cr_addr_i;
                flags_o.push = 1'b1;
            end
            NM_RET: begin
                if (ret_valid_i) begin
                    next_o      = ret_addr_i;
                    flags_o.pop = 1'b1;
                end else begin
                    next_o = STATE_W'(FETCH_STATE);
                end
            end
            NM_FETCH: next_o = STATE_W'(FETCH_STATE);
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Microprogram sequencer: state register, MOC wait counter, single-level
// return register, sticky bus error and saturating illegal-dispatch count.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int STATE_W     = 7,
    parameter int RESET_STATE = 0,
    parameter int FETCH_STATE = DEF_FETCH_STATE,
    parameter int ERR_STATE   = DEF_ERR_STATE,
    parameter int MOC_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] State_Sel,
    input  logic [2:0]         Next_Mode,
    input  logic [STATE_W-1:0] Cr_Addr,
    input  logic               Cond_In,
    input  logic               Inv,
    input  logic               MOC,
    output logic [STATE_W-1:0] State,
    output logic               Bus_Error,
    output logic [7:0]         Illegal_Cnt
);

    localparam int CNT_W = $clog2(MOC_TIMEOUT + 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [STATE_W-1:0] ret_q, ret_d;
    logic               ret_vld_q, ret_vld_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic               bus_err_q, bus_err_d;
    logic [7:0]         ill_q, ill_d;
    logic [STATE_W-1:0] next;
    logic               wait_done;
    ns_flags_t          flags;

    assign wait_done = (wait_q == CNT_W'(MOC_TIMEOUT));

    next_state_mux #(
        .STATE_W     (STATE_W),
        .FETCH_STATE (FETCH_STATE),
        .ERR_STATE   (ERR_STATE)
    ) u_mux (
        .state_i     (state_q),
        .mode_i      (Next_Mode),
        .sel_i       (State_Sel),
        .cr_addr_i   (Cr_Addr),
        .cond_i      (Cond_In),
        .inv_i       (Inv),
        .moc_i       (MOC),
        .wait_done_i (wait_done),
        .ret_valid_i (ret_vld_q),
        .ret_addr_i  (ret_q),
        .next_o      (next),
        .flags_o     (flags)
    );

    always_comb begin
        state_d   = next;
        bus_err_d = bus_err_q | flags.timeout;
        ill_d     = ill_q;
        if (flags.illegal && ill_q != 8'hFF)
            ill_d = ill_q + 8'd1;
        // only a held WAIT keeps counting; everything else restarts it
        wait_d    = flags.hold ? wait_q + CNT_W'(1) : '0;
        ret_d     = ret_q;
        ret_vld_d = ret_vld_q;
        if (flags.push) begin
            ret_d     = state_q + STATE_W'(1);
            ret_vld_d = 1'b1;
        end else if (flags.pop) begin
            ret_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= STATE_W'(RESET_STATE);
            ret_q     <= '0;
            ret_vld_q <= 1'b0;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
            ill_q     <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            ret_vld_q <= ret_vld_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
            ill_q     <= ill_d;
        end
    end

    assign State       = state_q;
    assign Bus_Error   = bus_err_q;
    assign Illegal_Cnt = ill_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: the driver queues the expected post-edge outputs,
// a monitor pops and compares them one cycle later.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] State_Sel = '0;
    logic [2:0] Next_Mode = '0;
    logic [6:0] Cr_Addr = '0;
    logic       Cond_In = 1'b0;
    logic       Inv = 1'b0;
    logic       MOC = 1'b0;
    logic [6:0] State;
    logic       Bus_Error;
    logic [7:0] Illegal_Cnt;

    localparam logic [2:0] ENC = 3'd0, INC = 3'd1, JMP = 3'd2, WT = 3'd3;
    localparam logic [2:0] CND = 3'd4, CAL = 3'd5, RET = 3'd6, FET = 3'd7;

    control_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .State_Sel   (State_Sel),
        .Next_Mode   (Next_Mode),
        .Cr_Addr     (Cr_Addr),
        .Cond_In     (Cond_In),
        .Inv         (Inv),
        .MOC         (MOC),
        .State       (State),
        .Bus_Error   (Bus_Error),
        .Illegal_Cnt (Illegal_Cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [6:0] st;
        logic       be;
        logic [7:0] ic;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   tag_n = 0;
    logic       exp_be = 1'b0;
    logic [7:0] exp_ic = 8'd0;

    task automatic step(input logic r, input logic [2:0] m,
                        input logic [6:0] a, input logic c,
                        input logic iv, input logic mc,
                        input logic [6:0] es);
        exp_t e;
        @(negedge clk);
        reset     = r;
        Next_Mode = m;
        State_Sel = a;
        Cr_Addr   = a;
        Cond_In   = c;
        Inv       = iv;
        MOC       = mc;
        e.tag = tag_n;
        e.st  = es;
        e.be  = exp_be;
        e.ic  = exp_ic;
        tag_n++;
        q.push_back(e);
    endtask

    task automatic do_reset();
        exp_be = 1'b0;
        exp_ic = 8'd0;
        step(1'b1, INC, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (State !== e.st || Bus_Error !== e.be ||
                    Illegal_Cnt !== e.ic) begin
                    errors++;
                    $display("FAIL step%0d: got State=%0d Bus_Error=%0b Illegal_Cnt=%0d, want %0d %0b %0d",
                             e.tag, State, Bus_Error, Illegal_Cnt,
                             e.st, e.be, e.ic);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin : driver
        do_reset();
        step(0, INC, 0, 0, 0, 0, 7'd1);
        step(0, INC, 0, 0, 0, 0, 7'd2);
        step(0, INC, 0, 0, 0, 0, 7'd3);
        do_reset();

        step(0, ENC, 7'd6, 0, 0, 0, 7'd6);
        exp_ic = 8'd1;
        step(0, ENC, 7'd1, 0, 0, 0, 7'd1);
        for (int i = 0; i < 300; i++) begin
            if (exp_ic != 8'd255) exp_ic = exp_ic + 8'd1;
            step(0, ENC, 7'd1, 0, 0, 0, 7'd1);
        end
        do_reset();

        step(0, JMP, 7'd20, 0, 0, 0, 7'd20);
        for (int i = 0; i < 5; i++)
            step(0, WT, 0, 0, 0, 0, 7'd20);
        step(0, WT, 0, 0, 0, 1, 7'd21);

        step(0, JMP, 7'd30, 0, 0, 0, 7'd30);
        for (int i = 0; i < 15; i++)
            step(0, WT, 0, 0, 0, 0, 7'd30);
        exp_be = 1'b1;
        step(0, WT, 0, 0, 0, 0, 7'd127);
        step(0, INC, 0, 0, 0, 0, 7'd0);
        step(0, FET, 0, 0, 0, 0, 7'd1);
        do_reset();

        step(0, JMP, 7'd40, 0, 0, 0, 7'd40);
        for (int i = 0; i < 15; i++)
            step(0, WT, 0, 0, 0, 0, 7'd40);
        step(0, WT, 0, 0, 0, 1, 7'd41);
        for (int i = 0; i < 15; i++)
            step(0, WT, 0, 0, 0, 0, 7'd41);
        step(0, WT, 0, 0, 0, 1, 7'd42);

        step(0, JMP, 7'd5, 0, 0, 0, 7'd5);
        step(0, CND, 7'd40, 1, 0, 0, 7'd40);
        step(0, CND, 7'd40, 1, 1, 0, 7'd41);
        step(0, CND, 7'd40, 0, 1, 0, 7'd40);
        step(0, CND, 7'd40, 0, 0, 0, 7'd41);

        step(0, JMP, 7'd10, 0, 0, 0, 7'd10);
        step(0, CAL, 7'd50, 0, 0, 0, 7'd50);
        step(0, RET, 7'd0, 0, 0, 0, 7'd11);
        step(0, RET, 7'd0, 0, 0, 0, 7'd1);

        step(0, JMP, 7'd10, 0, 0, 0, 7'd10);
        step(0, CAL, 7'd50, 0, 0, 0, 7'd50);
        step(0, INC, 7'd0, 0, 0, 0, 7'd51);
        step(0, CAL, 7'd60, 0, 0, 0, 7'd60);
        step(0, RET, 7'd0, 0, 0, 0, 7'd52);
        step(0, RET, 7'd0, 0, 0, 0, 7'd1);

        step(0, JMP, 7'd10, 0, 0, 0, 7'd10);
        step(1, CAL, 7'd50, 0, 0, 0, 7'd0);
        step(0, RET, 7'd0, 0, 0, 0, 7'd1);

        step(0, JMP, 7'd127, 0, 0, 0, 7'd127);
        step(0, INC, 7'd0, 0, 0, 0, 7'd0);

        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0",
                     q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
